// File: rtl/mem_access_unit.sv
// Memory-stage access controller: drives the data memory from the execute-stage
// request port, absorbs the one-cycle read latency and hands load results to write-back.
module mem_access_unit #(
    parameter int DSIZE     = 16,
    parameter int MEM_SPACE = 8,
    parameter int TAG_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [MEM_SPACE-1:0] req_addr,
    input  logic [DSIZE-1:0]     req_wdata,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [MEM_SPACE-1:0] mem_addr,
    output logic [DSIZE-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [DSIZE-1:0]     mem_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DSIZE-1:0]     rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [CNT_W-1:0]     load_cnt,
    output logic [CNT_W-1:0]     store_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RSP_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DSIZE-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]   store_cnt_q, store_cnt_d;
    logic               accept;
    logic               accept_load;
    logic               accept_store;

    // The tag of a newly accepted load is parked in pend_tag_q so the
    // presented rsp_tag only changes on entry to RSP_HOLD.
    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        pend_tag_d  = pend_tag_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        req_ready   = 1'b0;

        unique case (state_q)
            IDLE:      req_ready = 1'b1;
            LOAD_WAIT: req_ready = 1'b0;
            RSP_HOLD:  req_ready = rsp_ready;
            default:   req_ready = 1'b0;
        endcase
        if (rst) begin
            req_ready = 1'b0;
        end

        accept       = req_valid & req_ready;
        accept_load  = accept & ~req_we;
        accept_store = accept & req_we;

        unique case (state_q)
            IDLE: begin
                if (accept_load) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                rsp_data_d = mem_rdata;
                rsp_tag_d  = pend_tag_q;
                state_d    = RSP_HOLD;
            end
            RSP_HOLD: begin
                if (rsp_ready) begin
                    state_d = accept_load ? LOAD_WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_load) begin
            pend_tag_d = req_tag;
            load_cnt_d = load_cnt_q + 1'b1;
        end
        if (accept_store) begin
            store_cnt_d = store_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            pend_tag_q  <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            pend_tag_q  <= pend_tag_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign mem_we    = accept_store & ~rst;

    assign rsp_valid = (state_q == RSP_HOLD);
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle vector table against a behavioural
// registered-read memory, plus latency and counter-wrap sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_tag;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DSIZE(16),
        .MEM_SPACE(8),
        .TAG_W(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_tag(req_tag),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_tag(rsp_tag),
        .load_cnt(load_cnt),
        .store_cnt(store_cnt)
    );

    // Data memory: synchronous write, one-cycle registered read
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  tag;
        logic        rrdy;
        logic        e_rr;
        logic        e_we;
        logic        e_rv;
        logic [15:0] e_data;
        logic [3:0]  e_tag;
        logic [15:0] e_lc;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [3:0] t, input logic rr_in,
                       input logic e_rr, input logic e_we, input logic e_rv,
                       input logic [15:0] e_d, input logic [3:0] e_t,
                       input logic [15:0] e_lc, input logic [15:0] e_sc);
        vec_t x;
        x = '{r, v, we, a, d, t, rr_in, e_rr, e_we, e_rv, e_d, e_t, e_lc, e_sc};
        vecs.push_back(x);
    endtask

    initial begin
        int lat;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_tag = '0; rsp_ready = 1'b0;

        //  rst v we addr   wdata     tag rrdy | rr we rv data      tag lc sc
        add(1, 0, 0, 8'h00, 16'h0000, 0, 0,    0, 0, 0, 16'h0000, 0, 0, 0); // 0 reset
        add(1, 1, 1, 8'h05, 16'h1234, 0, 0,    0, 0, 0, 16'h0000, 0, 0, 0); // 1 reset blocks store
        add(0, 1, 1, 8'h05, 16'h1234, 0, 1,    1, 1, 0, 16'h0000, 0, 0, 0); // 2 store
        add(0, 1, 0, 8'h05, 16'h0000, 3, 1,    1, 0, 0, 16'h0000, 0, 0, 1); // 3 load 0x05
        add(0, 0, 0, 8'h05, 16'h0000, 0, 1,    0, 0, 0, 16'h0000, 0, 1, 1); // 4 LOAD_WAIT
        add(0, 0, 0, 8'h00, 16'h0000, 0, 1,    1, 0, 1, 16'h1234, 3, 1, 1); // 5 response
        add(0, 1, 1, 8'h10, 16'h00A0, 0, 1,    1, 1, 0, 16'h1234, 3, 1, 1); // 6 stores
        add(0, 1, 1, 8'h11, 16'h00A1, 0, 1,    1, 1, 0, 16'h1234, 3, 1, 2);
        add(0, 1, 1, 8'h12, 16'h00A2, 0, 1,    1, 1, 0, 16'h1234, 3, 1, 3);
        add(0, 1, 1, 8'h13, 16'h00A3, 0, 1,    1, 1, 0, 16'h1234, 3, 1, 4);
        add(0, 1, 0, 8'h12, 16'h0000, 7, 1,    1, 0, 0, 16'h1234, 3, 1, 5); // 10 load 0x12
        add(0, 1, 0, 8'h13, 16'h0000, 9, 1,    0, 0, 0, 16'h1234, 3, 2, 5); // 11 held, no accept
        add(0, 1, 0, 8'h13, 16'h0000, 9, 1,    1, 0, 1, 16'h00A2, 7, 2, 5); // 12 handoff load
        add(0, 1, 1, 8'h20, 16'h0055, 0, 0,    0, 0, 0, 16'h00A2, 7, 3, 5); // 13 store held
        for (int i = 0; i < 5; i++)
            add(0, 1, 1, 8'h20, 16'h0055, 0, 0, 0, 0, 1, 16'h00A3, 9, 3, 5); // 14-18 backpressure
        add(0, 1, 1, 8'h20, 16'h0055, 0, 1,    1, 1, 1, 16'h00A3, 9, 3, 5); // 19 release
        add(0, 1, 0, 8'h20, 16'h0000, 2, 1,    1, 0, 0, 16'h00A3, 9, 3, 6); // 20 load 0x20
        add(1, 0, 0, 8'h00, 16'h0000, 0, 1,    0, 0, 0, 16'h00A3, 9, 4, 6); // 21 reset in LOAD_WAIT
        add(0, 0, 0, 8'h00, 16'h0000, 0, 1,    1, 0, 0, 16'h0000, 0, 0, 0); // 22
        add(0, 0, 0, 8'h00, 16'h0000, 0, 1,    1, 0, 0, 16'h0000, 0, 0, 0); // 23 no late response

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req_valid = vecs[i].v; req_we = vecs[i].we;
            req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            req_tag = vecs[i].tag; rsp_ready = vecs[i].rrdy;
            @(negedge clk);
            check("req_ready", i, 32'(req_ready), 32'(vecs[i].e_rr));
            check("mem_we",    i, 32'(mem_we),    32'(vecs[i].e_we));
            check("rsp_valid", i, 32'(rsp_valid), 32'(vecs[i].e_rv));
            check("rsp_data",  i, 32'(rsp_data),  32'(vecs[i].e_data));
            check("rsp_tag",   i, 32'(rsp_tag),   32'(vecs[i].e_tag));
            check("load_cnt",  i, 32'(load_cnt),  32'(vecs[i].e_lc));
            check("store_cnt", i, 32'(store_cnt), 32'(vecs[i].e_sc));
            check("mem_addr",  i, 32'(mem_addr),  32'(vecs[i].addr));
            @(posedge clk); #1;
        end

        // Load latency: 0x11 holds 0xA1 from the store burst
        rst = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h11; req_tag = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("load_latency", 0, 32'(lat), 32'd2);
        check("lat_rsp_data", 0, 32'(rsp_data), 32'h00A1);
        check("lat_rsp_tag",  0, 32'(rsp_tag),  32'd5);
        @(posedge clk); #1;
        check("lat_drained", 0, 32'(rsp_valid), 32'd0);

        // Store counter wrap
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 16'h7777;
        repeat (65535) @(posedge clk);
        #1;
        @(negedge clk);
        check("wrap_ffff", 0, 32'(store_cnt), 32'h0000FFFF);
        @(posedge clk); #1;
        check("wrap_zero", 0, 32'(store_cnt), 32'h00000000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wrap_one",  0, 32'(store_cnt), 32'h00000001);
        check("wrap_lcnt", 0, 32'(load_cnt),  32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting directly upstream of the data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and drives the memory's address, write-data and write-enable inputs. It accounts for the memory's one-cycle registered read latency, captures load data, and presents it to write-back over a second valid/ready handshake. It also keeps wrapping load/store event counters for debug.

## Interface

Parameters:
- DSIZE, 16, data word width; equals memory word width
- MEM_SPACE, 8, address width; equals memory address width
- TAG_W, 4, destination-register tag width
- CNT_W, 16, event counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit accepts the request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  MEM_SPACE  word address
- req_wdata  in  DSIZE  store data
- req_tag  in  TAG_W  destination register of a load
- mem_addr  out  MEM_SPACE  to memory address
- mem_wdata  out  DSIZE  to memory data_in
- mem_we  out  1  to memory write_en, active-high
- mem_rdata  in  DSIZE  from memory data_out; valid the cycle after the address was sampled
- rsp_valid  out  1  load result available
- rsp_ready  in  1  write-back accepts result
- rsp_data  out  DSIZE  load result
- rsp_tag  out  TAG_W  tag of the load
- load_cnt  out  CNT_W  accepted loads, wraps
- store_cnt  out  CNT_W  accepted stores, wraps

## Operation

- accept = req_valid & req_ready. A store is accepted and completes in one cycle. A load is accepted and then occupies the unit until its response is taken.
- FSM states:
  - IDLE: req_ready=1. On accepted load go to LOAD_WAIT, registering req_tag. On accepted store stay in IDLE.
  - LOAD_WAIT: req_ready=0. Capture mem_rdata into rsp_data, set rsp_valid=1, go to RSP_HOLD.
  - RSP_HOLD: rsp_valid=1. req_ready=rsp_ready.
    - rsp_ready=0: stay, holding rsp_data and rsp_tag stable.
    - rsp_ready=1 with no accept: go to IDLE.
    - rsp_ready=1 with accepted load: go to LOAD_WAIT.
    - rsp_ready=1 with accepted store: go to IDLE.
- Memory drive is combinational from the request port:
  - mem_addr=req_addr and mem_wdata=req_wdata at all times.
  - mem_we = accept & req_we & ~rst.
- In LOAD_WAIT, mem_addr still follows req_addr. No write can occur because req_ready=0.
- Store data is never forwarded. A load accepted the cycle after a store to the same address reads the new value, because the memory has already written it.
- Counters:
  - load_cnt increments on each accepted load; store_cnt on each accepted store.
  - Both wrap from 2^CNT_W-1 to 0.
- Reset (rst=1 at an edge): state=IDLE, rsp_valid=0, rsp_data=0, rsp_tag=0, load_cnt=0, store_cnt=0.
- While rst=1, req_ready=0 and mem_we=0 combinationally.
- Reset mid-operation: an in-flight load or held response is discarded, with no response.

## Timing

- Store: accepted in cycle N; memory written at the edge ending N.
- Load: accepted in cycle N; memory samples the address at the edge ending N; mem_rdata is valid in N+1.
  - The unit captures at the edge ending N+1, so rsp_valid=1 from cycle N+2.
  - Load-to-response latency is 2 cycles.
- Throughput:
  - One store per cycle.
  - One load per 2 cycles when rsp_ready is held high (RSP_HOLD accepts the next load at the handoff).
- A request cannot be accepted during LOAD_WAIT. req_valid may stay high; the request must be held stable until accepted.
- rsp_data and rsp_tag change only on the edge entering RSP_HOLD.

## Test plan

- Reset check: drive rst=1 for 2 cycles -> rsp_valid=0, rsp_data=0, load_cnt=store_cnt=0, req_ready=0, mem_we=0 during rst; req_ready=1 in the first cycle after rst falls.
- Store then load: store 0x1234 to address 0x05, then load 0x05 with tag 3 (rsp_ready=1) -> mem_we=1 only in the store cycle; rsp_valid rises 2 cycles after load accept with rsp_data=0x1234 and rsp_tag=3; store_cnt=1, load_cnt=1.
- Back-to-back stores: 4 consecutive stores to addresses 0x10–0x13 with data 0xA0–0xA3 -> req_ready stays 1, mem_we high for 4 cycles; a subsequent load of 0x12 returns 0xA2.
- Response backpressure: load with rsp_ready=0 for 5 cycles, next request (a store) held on req_valid -> rsp_data and rsp_tag stable, req_ready=0, mem_we=0 throughout; the cycle rsp_ready=1, the store is accepted and the FSM returns to IDLE.
- Reset mid-load: assert rst in the LOAD_WAIT cycle -> no rsp_valid ever appears for that load; counters are 0 after the reset.
- Counter wrap: preload via 65536 stores, then one more store -> store_cnt goes 0xFFFF -> 0x0000 -> 0x0001 across the sequence.
